z80_sdram_responder: RTL and testbench



---
 rtl/z80_sdram_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_z80_sdram_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_sdram_responder.sv
// z80_sdram_responder: serves Z80 byte accesses in the $8000-$FFFF window from
// a 16-bit SDRAM. Each access is one ACTIVATE / READ|WRITE / PRECHARGE
// sequence on bank 0. The block also owns power-up init and periodic refresh.
module z80_sdram_responder #(
    parameter int INIT_WAIT      = 20000,
    parameter int T_RCD          = 3,
    parameter int CAS_LAT        = 2,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 7,
    parameter int REFRESH_CYCLES = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [14:0] i_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_ack,
    output logic        o_init_done,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    inout  wire  [15:0] sdram_dq,
    output logic        sdram_ldqm,
    output logic        sdram_udqm,
    output logic        sdram_ras,
    output logic        sdram_cas,
    output logic        sdram_we
);

    // {ras, cas, we}
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_LMR   = 3'b000;

    // One shared wait counter; sized to hold the longest delay loaded into it.
    localparam int WAIT_MAX = INIT_WAIT + T_RFC + T_RP + T_RCD + CAS_LAT + 2;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REF_W    = $clog2(REFRESH_CYCLES + 1);

    // Init steps wait the full gap, then issue the next command directly.
    localparam logic [WAIT_W-1:0] W_INIT = WAIT_W'(INIT_WAIT);
    localparam logic [WAIT_W-1:0] W_RP   = WAIT_W'(T_RP);
    localparam logic [WAIT_W-1:0] W_RFC  = WAIT_W'(T_RFC);
    localparam logic [WAIT_W-1:0] W_MODE = WAIT_W'(2);
    // Run-time steps return to IDLE one cycle early so IDLE itself is the
    // last NOP of the gap and can issue the next command on its first edge.
    localparam logic [WAIT_W-1:0] W_RCD1 = WAIT_W'(T_RCD - 1);
    localparam logic [WAIT_W-1:0] W_CL1  = WAIT_W'(CAS_LAT - 1);
    localparam logic [WAIT_W-1:0] W_RP1  = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] W_RFC1 = WAIT_W'(T_RFC - 1);
    localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(REFRESH_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MODE,
        ST_IDLE, ST_ACT, ST_RW, ST_CAS_WAIT, ST_PRE, ST_REF
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [REF_W-1:0]    ref_cnt;
    logic                ref_pending;
    logic                ref_expire;
    logic [2:0]          cmd;
    logic                dq_oe;
    logic [15:0]         dq_out;
    logic                acc_wr;
    logic                acc_hi;
    logic [7:0]          acc_col;
    logic [7:0]          acc_data;

    assign {sdram_ras, sdram_cas, sdram_we} = cmd;
    assign sdram_dq = dq_oe ? dq_out : 16'bz;

    // An expiry seen in IDLE is served on the same edge, ahead of a request.
    assign ref_expire = o_init_done && (ref_cnt == '0);

    // Init, refresh timer and access sequencer; every pin is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT_WAIT;
            wait_cnt    <= W_INIT;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
            cmd         <= CMD_NOP;
            sdram_addr  <= '0;
            sdram_bank  <= '0;
            sdram_ldqm  <= 1'b1;
            sdram_udqm  <= 1'b1;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            o_ack       <= 1'b0;
            o_data      <= '0;
            o_init_done <= 1'b0;
            acc_wr      <= 1'b0;
            acc_hi      <= 1'b0;
            acc_col     <= '0;
            acc_data    <= '0;
        end else begin
            cmd        <= CMD_NOP;
            sdram_ldqm <= 1'b1;
            sdram_udqm <= 1'b1;
            dq_oe      <= 1'b0;
            o_ack      <= 1'b0;

            // Free-running refresh timer; a repeat expiry while pending is dropped.
            if (o_init_done) begin
                if (ref_cnt == '0) begin
                    ref_cnt     <= REF_RELOAD;
                    ref_pending <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt - 1'b1;
                end
            end

            case (state)
                ST_INIT_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        cmd        <= CMD_PRE;
                        sdram_addr <= 12'h400;  // A10: all banks
                        wait_cnt   <= W_RP;
                        state      <= ST_INIT_PRE;
                    end
                end
                ST_INIT_PRE: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        cmd      <= CMD_REF;
                        wait_cnt <= W_RFC;
                        state    <= ST_INIT_REF1;
                    end
                end
                ST_INIT_REF1: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        cmd      <= CMD_REF;
                        wait_cnt <= W_RFC;
                        state    <= ST_INIT_REF2;
                    end
                end
                ST_INIT_REF2: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        cmd        <= CMD_LMR;
                        sdram_addr <= 12'h020;  // BL1, sequential, CL2
                        wait_cnt   <= W_MODE;
                        state      <= ST_INIT_MODE;
                    end
                end
                ST_INIT_MODE: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        o_init_done <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ref_pending || ref_expire) begin
                        cmd         <= CMD_REF;
                        ref_pending <= 1'b0;
                        wait_cnt    <= W_RFC1;
                        state       <= ST_REF;
                    end else if (i_req) begin
                        cmd        <= CMD_ACT;
                        sdram_bank <= 2'b00;
                        sdram_addr <= {6'b0, i_addr[14:9]};
                        acc_wr     <= i_wr;
                        acc_hi     <= i_addr[0];
                        acc_col    <= i_addr[8:1];
                        acc_data   <= i_data;
                        wait_cnt   <= W_RCD1;
                        state      <= ST_ACT;
                    end
                end
                ST_ACT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        sdram_addr <= {4'b0, acc_col};  // A10 low: no auto-precharge
                        if (acc_wr) begin
                            cmd        <= CMD_WRITE;
                            dq_oe      <= 1'b1;
                            dq_out     <= {acc_data, acc_data};
                            sdram_ldqm <= acc_hi;
                            sdram_udqm <= ~acc_hi;
                        end else begin
                            cmd        <= CMD_READ;
                            sdram_ldqm <= 1'b0;
                            sdram_udqm <= 1'b0;
                        end
                        state <= ST_RW;
                    end
                end
                ST_RW: begin
                    if (acc_wr) begin
                        cmd        <= CMD_PRE;
                        sdram_addr <= '0;
                        o_ack      <= 1'b1;
                        wait_cnt   <= W_RP1;
                        state      <= ST_PRE;
                    end else begin
                        wait_cnt <= W_CL1;
                        state    <= ST_CAS_WAIT;
                    end
                end
                ST_CAS_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else begin
                        o_data     <= acc_hi ? sdram_dq[15:8] : sdram_dq[7:0];
                        o_ack      <= 1'b1;
                        cmd        <= CMD_PRE;
                        sdram_addr <= '0;
                        wait_cnt   <= W_RP1;
                        state      <= ST_PRE;
                    end
                end
                ST_PRE, ST_REF: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    else state <= ST_IDLE;
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_sdram_responder.sv
// Directed bench for z80_sdram_responder: init sequence, table-driven accesses,
// refresh collision/count, back-to-back requests and reset during an access.
module tb_z80_sdram_responder;

    localparam int IW   = 16;
    localparam int TRCD = 3;
    localparam int CL   = 2;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int RC   = 64;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101,
                           C_WR  = 3'b100, C_PRE = 3'b010, C_REF = 3'b001,
                           C_LMR = 3'b000;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [15:0] mem;
        logic [11:0] row;
        logic [7:0]  col;
        logic        ldqm;
        logic        udqm;
        logic [15:0] dq;
        logic [7:0]  rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic        i_wr = 1'b0;
    logic [14:0] i_addr = '0;
    logic [7:0]  i_data = '0;
    logic [7:0]  o_data;
    logic        o_ack, o_init_done;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    wire  [15:0] sdram_dq;
    logic        sdram_ldqm, sdram_udqm, sdram_ras, sdram_cas, sdram_we;

    logic        dq_en = 1'b0;
    logic [15:0] dq_val = '0;
    logic [15:0] mem_word = '0;
    int          rd_dly = 0;
    int          dq_hold = 0;
    int          errors = 0;
    int          checks = 0;
    int          ref_seen = 0;
    int          ncyc = 0;
    bit          mon_en = 1'b0;
    vec_t        vecs[8];

    wire [2:0] cmd = {sdram_ras, sdram_cas, sdram_we};

    assign sdram_dq = dq_en ? dq_val : 16'bz;

    z80_sdram_responder #(
        .INIT_WAIT(IW), .T_RCD(TRCD), .CAS_LAT(CL), .T_RP(TRP),
        .T_RFC(TRFC), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
        .i_data(i_data), .o_data(o_data), .o_ack(o_ack), .o_init_done(o_init_done),
        .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .sdram_dq(sdram_dq),
        .sdram_ldqm(sdram_ldqm), .sdram_udqm(sdram_udqm), .sdram_ras(sdram_ras),
        .sdram_cas(sdram_cas), .sdram_we(sdram_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc++;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // SDRAM data model (CL2 after a READ) plus pin-level monitors.
    always @(negedge clk) begin
        if (dq_hold > 0) begin
            dq_hold--;
            if (dq_hold == 0) dq_en = 1'b0;
        end
        if (rd_dly > 0) begin
            rd_dly--;
            if (rd_dly == 0) begin
                dq_val  = mem_word;
                dq_en   = 1'b1;
                dq_hold = 1;
            end
        end
        if (cmd == C_RD) rd_dly = CL;
        if (cmd == C_REF) ref_seen++;
        if (mon_en && cmd != C_RD && cmd != C_WR)
            chk("idle_masks", int'({sdram_ldqm, sdram_udqm}), 3);
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"},   int'(cmd), int'(C_NOP));
        chk({tag, "_addr"},  int'(sdram_addr), 0);
        chk({tag, "_bank"},  int'(sdram_bank), 0);
        chk({tag, "_masks"}, int'({sdram_ldqm, sdram_udqm}), 3);
        chk({tag, "_ack"},   int'(o_ack), 0);
        chk({tag, "_data"},  int'(o_data), 0);
        chk({tag, "_done"},  int'(o_init_done), 0);
    endtask

    // Follows the init sequence cycle by cycle from reset release.
    task automatic run_init(input string tag);
        int          len, bad;
        logic [2:0]  expc;
        logic        pre_a10, early_done, ack_seen;
        logic [11:0] lmr_addr;
        len = IW + TRP + 2 * TRFC + 6;
        bad = 0; pre_a10 = 1'b0; early_done = 1'b0; ack_seen = 1'b0; lmr_addr = '0;
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            expc = C_NOP;
            if (j == IW + 1) expc = C_PRE;
            else if (j == IW + TRP + 2) expc = C_REF;
            else if (j == IW + TRP + TRFC + 3) expc = C_REF;
            else if (j == IW + TRP + 2 * TRFC + 4) expc = C_LMR;
            if (cmd !== expc) bad++;
            if (j == IW + 1) pre_a10 = sdram_addr[10];
            if (j == IW + TRP + 2 * TRFC + 4) lmr_addr = sdram_addr;
            if (o_init_done) early_done = 1'b1;
            if (o_ack) ack_seen = 1'b1;
        end
        chk({tag, "_seq_bad_cycles"}, bad, 0);
        chk({tag, "_pre_a10"}, int'(pre_a10), 1);
        chk({tag, "_mode_word"}, int'(lmr_addr), 'h020);
        chk({tag, "_done_early"}, int'(early_done), 0);
        chk({tag, "_ack_during_init"}, int'(ack_seen), 0);
        @(negedge clk);
        chk({tag, "_done"}, int'(o_init_done), 1);
    endtask

    // One access: captures ACTIVE and READ/WRITE pins, checks mapping and latency.
    task automatic do_access(input vec_t v, input string tag);
        int          t_act, t_ack;
        logic        got_act, got_rw, got_ack;
        logic [11:0] act_addr, rw_addr;
        logic [1:0]  act_bank;
        logic        rw_l, rw_u;
        logic [15:0] rw_dq;
        logic [7:0]  rd;
        logic [2:0]  ack_cmd;
        t_act = -100; t_ack = -1; got_act = 1'b0; got_rw = 1'b0; got_ack = 1'b0;
        act_addr = '0; rw_addr = '0; act_bank = '0; rw_l = 1'b0; rw_u = 1'b0;
        rw_dq = '0; rd = '0; ack_cmd = C_NOP;
        mem_word = v.mem;
        i_wr = v.wr; i_addr = v.addr; i_data = v.wdata; i_req = 1'b1;
        for (int n = 1; n <= 40 && !got_ack; n++) begin
            @(negedge clk);
            if (cmd == C_ACT && !got_act) begin
                got_act = 1'b1; t_act = n; act_addr = sdram_addr; act_bank = sdram_bank;
            end
            if ((cmd == C_RD || cmd == C_WR) && got_act && !got_rw) begin
                got_rw = 1'b1; rw_addr = sdram_addr; rw_l = sdram_ldqm; rw_u = sdram_udqm;
                rw_dq = sdram_dq;
            end
            if (o_ack) begin
                got_ack = 1'b1; t_ack = n; rd = o_data; ack_cmd = cmd; i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        chk({tag, "_ack_seen"}, int'(got_ack), 1);
        chk({tag, "_bank"}, int'(act_bank), 0);
        chk({tag, "_row"}, int'(act_addr), int'(v.row));
        chk({tag, "_col"}, int'(rw_addr), int'({4'b0, v.col}));
        chk({tag, "_masks"}, int'({rw_l, rw_u}), int'({v.ldqm, v.udqm}));
        if (v.wr) chk({tag, "_dq"}, int'(rw_dq), int'(v.dq));
        else      chk({tag, "_rdata"}, int'(rd), int'(v.rdata));
        chk({tag, "_lat"}, t_ack - t_act, v.wr ? TRCD + 1 : TRCD + CL + 1);
        chk({tag, "_ack_pre"}, int'(ack_cmd), int'(C_PRE));
        @(negedge clk);
        chk({tag, "_ack_1cyc"}, int'(o_ack), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start, r0, lat, nack, nact, t_ack1, t_act2;
        logic found, ack_after;
        logic [2:0] first_cmd;
        logic [7:0] rd2;

        vecs[0] = '{1'b1, 15'h0001, 8'hA5, 16'h0000, 12'h000, 8'h00, 1'b1, 1'b0, 16'hA5A5, 8'h00};
        vecs[1] = '{1'b0, 15'h0001, 8'h00, 16'hA53C, 12'h000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hA5};
        vecs[2] = '{1'b1, 15'h7FFE, 8'h5A, 16'h0000, 12'h03F, 8'hFF, 1'b0, 1'b1, 16'h5A5A, 8'h00};
        vecs[3] = '{1'b0, 15'h7FFE, 8'h00, 16'h12C3, 12'h03F, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'hC3};
        vecs[4] = '{1'b1, 15'h1234, 8'h0F, 16'h0000, 12'h009, 8'h1A, 1'b0, 1'b1, 16'h0F0F, 8'h00};
        vecs[5] = '{1'b0, 15'h4C01, 8'h00, 16'hBEEF, 12'h026, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hBE};
        vecs[6] = '{1'b0, 15'h0200, 8'h00, 16'h00FF, 12'h001, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hFF};
        vecs[7] = '{1'b1, 15'h01FF, 8'h80, 16'h0000, 12'h000, 8'hFF, 1'b1, 1'b0, 16'h8080, 8'h00};

        // Reset values, then init with a request already pending.
        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        mon_en = 1'b1;
        i_req = 1'b1; i_wr = 1'b0; i_addr = 15'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_init("init");
        i_req = 1'b0;

        foreach (vecs[i]) do_access(vecs[i], $sformatf("v%0d", i));

        // Align to a refresh issued with no traffic in the way.
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            found = 1'b0;
            for (int n = 0; n < RC + 40 && !found; n++) begin
                @(negedge clk);
                if (cmd == C_REF) found = 1'b1;
            end
        end
        chk("ref_align", int'(found), 1);
        #1;
        start = ncyc;
        r0 = ref_seen;

        // Request arrives on the edge where the timer expires.
        repeat (RC - 1) @(negedge clk);
        i_wr = 1'b1; i_addr = 15'h2345; i_data = 8'h3C; i_req = 1'b1;
        lat = -1; first_cmd = C_NOP;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) first_cmd = cmd;
            if (o_ack) begin
                lat = n; i_req = 1'b0;
                break;
            end
        end
        i_req = 1'b0;
        chk("collide_ref_first", int'(first_cmd), int'(C_REF));
        chk("collide_ack_lat", lat, TRFC + TRCD + 3);

        // Request held through ack: second access starts T_RP+1 after ack.
        repeat (4) @(negedge clk);
        mem_word = 16'h7E81;
        i_wr = 1'b0; i_addr = 15'h0010; i_req = 1'b1;
        nack = 0; nact = 0; t_ack1 = -100; t_act2 = -1; ack_after = 1'b1; rd2 = '0;
        for (int n = 1; n <= 60 && nack < 2; n++) begin
            @(negedge clk);
            if (cmd == C_ACT) begin
                nact++;
                if (nact == 2) t_act2 = n;
            end
            if (nack == 1 && n == t_ack1 + 1) ack_after = o_ack;
            if (o_ack) begin
                nack++;
                if (nack == 1) t_ack1 = n;
                else begin
                    rd2 = o_data; i_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        chk("b2b_acks", nack, 2);
        chk("b2b_ack_1cyc", int'(ack_after), 0);
        chk("b2b_next_act", t_act2 - t_ack1, TRP + 1);
        chk("b2b_rdata", int'(rd2), 'h81);

        // Ten refresh intervals since alignment: exactly ten refreshes.
        while (ncyc < start + 10 * RC) @(negedge clk);
        #1;
        chk("refresh_count", ref_seen - r0, 10);

        // Reset between ACTIVE and READ: access abandoned, init reruns.
        @(negedge clk);
        i_wr = 1'b0; i_addr = 15'h7E03; i_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (cmd == C_ACT) found = 1'b1;
        end
        chk("midrd_act_seen", int'(found), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("midrd");
        i_req = 1'b0;
        @(negedge clk);
        chk("midrd_no_ack", int'(o_ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init("reinit");

        do_access(vecs[5], "post_reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
